// File: rtl/uart_mmr.sv
// uart_mmr: memory-mapped 8N1 UART with a transmit FIFO.
// Registers: TXDATA 0x1000_0000 (W), RXDATA 0x1000_0004 (R), STATUS 0x1000_0008 (R).
// Optional receiver: define COTM32_UART_RX_EN to build it; without it RXDATA and
// STATUS[3:2] read 0 and rx is ignored.
module uart_mmr #(
   parameter int XLEN          = 32,
   parameter int BAUD_DIV      = 8680,
   parameter int TX_FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sel,
   input  logic [XLEN-1:0] addr,
   input  logic            we,
   input  logic            re,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata,
   output logic            tx,
   input  logic            rx
);
   localparam int PW = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0]   BAUD_LAST   = CW'(BAUD_DIV - 1);
   localparam logic [PW:0]     FIFO_FULL   = (PW+1)'(TX_FIFO_DEPTH);
   localparam logic [XLEN-1:0] ADDR_TXDATA = XLEN'(32'h1000_0000);
   localparam logic [XLEN-1:0] ADDR_RXDATA = XLEN'(32'h1000_0004);
   localparam logic [XLEN-1:0] ADDR_STATUS = XLEN'(32'h1000_0008);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   // Bus decode (full address compare)
   logic wr_tx_s, rd_s, rd_status_s, rd_rxdata_s;
   assign wr_tx_s     = sel & we & (addr == ADDR_TXDATA);
   assign rd_s        = sel & re;
   assign rd_status_s = rd_s & (addr == ADDR_STATUS);
   assign rd_rxdata_s = rd_s & (addr == ADDR_RXDATA);

   // Transmit FIFO
   logic [7:0]    fifo_mem_r [TX_FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r, rd_ptr_r;
   logic [PW:0]   count_r;
   logic          fifo_full_s, fifo_empty_s, push_s, pop_s, overflow_set_s;
   assign fifo_full_s    = (count_r == FIFO_FULL);
   assign fifo_empty_s   = (count_r == (PW+1)'(0));
   // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted
   assign push_s         = wr_tx_s & (~fifo_full_s | pop_s);
   assign overflow_set_s = wr_tx_s & fifo_full_s & ~pop_s;

   // FIFO storage, wrapping pointers and fill count
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= (PW+1)'(0);
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= wdata[7:0];
            wr_ptr_r             <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Transmitter
   tx_state_t     tx_state_r, tx_state_next_s;
   logic [CW-1:0] tx_cnt_r, tx_cnt_next_s;
   logic [2:0]    tx_bit_r, tx_bit_next_s;
   logic [7:0]    tx_shift_r, tx_shift_next_s;
   logic          tx_r, tx_next_s, tx_done_s;
   assign tx_done_s = (tx_cnt_r == BAUD_LAST);

   // TX next state, FIFO pop and the serial level for the next cycle
   always_comb begin
      tx_state_next_s = tx_state_r;
      tx_cnt_next_s   = tx_cnt_r;
      tx_bit_next_s   = tx_bit_r;
      tx_shift_next_s = tx_shift_r;
      pop_s           = 1'b0;
      case (tx_state_r)
         TX_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s           = 1'b1;
               tx_shift_next_s = fifo_mem_r[rd_ptr_r];
               tx_cnt_next_s   = CW'(0);
               tx_state_next_s = TX_START;
            end else begin
               tx_state_next_s = TX_IDLE;
            end
         end
         TX_START: begin
            if (tx_done_s) begin
               tx_cnt_next_s   = CW'(0);
               tx_bit_next_s   = 3'd0;
               tx_state_next_s = TX_DATA;
            end else begin
               tx_cnt_next_s = tx_cnt_r + CW'(1);
            end
         end
         TX_DATA: begin
            if (tx_done_s) begin
               tx_cnt_next_s = CW'(0);
               if (tx_bit_r == 3'd7) begin
                  tx_state_next_s = TX_STOP;
               end else begin
                  tx_bit_next_s = tx_bit_r + 3'd1;
               end
            end else begin
               tx_cnt_next_s = tx_cnt_r + CW'(1);
            end
         end
         TX_STOP: begin
            if (tx_done_s) begin
               tx_cnt_next_s = CW'(0);
               // Chain straight into the next start bit when more data is queued
               if (!fifo_empty_s) begin
                  pop_s           = 1'b1;
                  tx_shift_next_s = fifo_mem_r[rd_ptr_r];
                  tx_state_next_s = TX_START;
               end else begin
                  tx_state_next_s = TX_IDLE;
               end
            end else begin
               tx_cnt_next_s = tx_cnt_r + CW'(1);
            end
         end
         default: tx_state_next_s = TX_IDLE;
      endcase
      case (tx_state_next_s)
         TX_START: tx_next_s = 1'b0;
         TX_DATA:  tx_next_s = tx_shift_next_s[tx_bit_next_s];
         default:  tx_next_s = 1'b1;
      endcase
   end

   // TX state register; tx itself is registered so it never glitches
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= CW'(0);
         tx_bit_r   <= 3'd0;
         tx_shift_r <= 8'h00;
         tx_r       <= 1'b1;
      end else begin
         tx_state_r <= tx_state_next_s;
         tx_cnt_r   <= tx_cnt_next_s;
         tx_bit_r   <= tx_bit_next_s;
         tx_shift_r <= tx_shift_next_s;
         tx_r       <= tx_next_s;
      end
   end
   assign tx = tx_r;

   // Sticky TX overflow; a new overflow wins over a clearing STATUS read
   logic tx_overflow_r;
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_overflow_r <= 1'b0;
      end else if (overflow_set_s) begin
         tx_overflow_r <= 1'b1;
      end else if (rd_status_s) begin
         tx_overflow_r <= 1'b0;
      end
   end

   logic [7:0] rx_byte_s;
   logic       rx_valid_s, rx_overrun_s;

`ifdef COTM32_UART_RX_EN
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

   rx_state_t     rx_state_r, rx_state_next_s;
   logic [CW-1:0] rx_cnt_r, rx_cnt_next_s;
   logic [2:0]    rx_bit_r, rx_bit_next_s;
   logic [7:0]    rx_shift_r, rx_shift_next_s, rx_byte_r;
   logic          rx_meta_r, rx_sync_r, rx_prev_r, rx_done_s, rx_valid_r, rx_overrun_r;
   logic          unused_s;
   assign unused_s = ^wdata[XLEN-1:8];

   // Two-flop synchronizer plus previous sample for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
      end
   end

   // RX next state: re-check start at half a bit, then sample each bit mid-way
   always_comb begin
      rx_state_next_s = rx_state_r;
      rx_cnt_next_s   = rx_cnt_r;
      rx_bit_next_s   = rx_bit_r;
      rx_shift_next_s = rx_shift_r;
      rx_done_s       = 1'b0;
      case (rx_state_r)
         RX_IDLE: begin
            if (rx_prev_r & ~rx_sync_r) begin
               rx_cnt_next_s   = CW'(0);
               rx_state_next_s = RX_START;
            end else begin
               rx_state_next_s = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_cnt_r == HALF_LAST) begin
               rx_cnt_next_s = CW'(0);
               rx_bit_next_s = 3'd0;
               // A line already back high was a glitch, not a start bit
               rx_state_next_s = rx_sync_r ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_next_s = rx_cnt_r + CW'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_r == BAUD_LAST) begin
               rx_cnt_next_s   = CW'(0);
               rx_shift_next_s = {rx_sync_r, rx_shift_r[7:1]};
               if (rx_bit_r == 3'd7) begin
                  rx_state_next_s = RX_STOP;
               end else begin
                  rx_bit_next_s = rx_bit_r + 3'd1;
               end
            end else begin
               rx_cnt_next_s = rx_cnt_r + CW'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt_r == BAUD_LAST) begin
               rx_cnt_next_s   = CW'(0);
               rx_done_s       = 1'b1;
               rx_state_next_s = RX_IDLE;
            end else begin
               rx_cnt_next_s = rx_cnt_r + CW'(1);
            end
         end
         default: rx_state_next_s = RX_IDLE;
      endcase
   end

   // RX state, holding register and flags; a new byte overwrites an unread one
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_r   <= RX_IDLE;
         rx_cnt_r     <= CW'(0);
         rx_bit_r     <= 3'd0;
         rx_shift_r   <= 8'h00;
         rx_byte_r    <= 8'h00;
         rx_valid_r   <= 1'b0;
         rx_overrun_r <= 1'b0;
      end else begin
         rx_state_r <= rx_state_next_s;
         rx_cnt_r   <= rx_cnt_next_s;
         rx_bit_r   <= rx_bit_next_s;
         rx_shift_r <= rx_shift_next_s;
         if (rx_done_s) begin
            rx_byte_r  <= rx_shift_r;
            rx_valid_r <= 1'b1;
         end else if (rd_rxdata_s) begin
            rx_valid_r <= 1'b0;
         end
         if (rx_done_s & rx_valid_r) begin
            rx_overrun_r <= 1'b1;
         end else if (rd_status_s) begin
            rx_overrun_r <= 1'b0;
         end
      end
   end

   assign rx_byte_s    = rx_byte_r;
   assign rx_valid_s   = rx_valid_r;
   assign rx_overrun_s = rx_overrun_r;
`else
   logic unused_s;
   assign unused_s     = ^{wdata[XLEN-1:8], rx, rd_rxdata_s};
   assign rx_byte_s    = 8'h00;
   assign rx_valid_s   = 1'b0;
   assign rx_overrun_s = 1'b0;
`endif

   logic       tx_idle_s;
   logic [4:0] status_s;
   assign tx_idle_s = fifo_empty_s & (tx_state_r == TX_IDLE);
   assign status_s  = {tx_overflow_r, rx_overrun_s, rx_valid_s, tx_idle_s, fifo_full_s};

   // Registered read data; unmapped addresses and write-only TXDATA return 0
   logic [XLEN-1:0] rdata_r;
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r <= XLEN'(0);
      end else if (rd_s) begin
         if (addr == ADDR_RXDATA) begin
            rdata_r <= XLEN'(rx_byte_s);
         end else if (addr == ADDR_STATUS) begin
            rdata_r <= XLEN'(status_s);
         end else begin
            rdata_r <= XLEN'(0);
         end
      end
   end
   assign rdata = rdata_r;

endmodule

// File: doc/uart_mmr.md
UART_MMR -- requirements
Module: uart_mmr

Interface
REQ-001 The module SHALL have parameter BAUD_DIV, default 8680 (CLK_FREQ/115200), giving clock cycles per serial bit (legal range 4 or more).
REQ-002 The module SHALL have parameter TX_FIFO_DEPTH, default 4 (power of two, 2 or more), giving the number of transmit FIFO entries.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port sel, input, 1 bit: the interconnect decoded an address in UART_MEM_START..UART_MEM_END.
REQ-006 The module SHALL have port addr, input, XLEN bits: the byte address of the access.
REQ-007 The module SHALL have port we, input, 1 bit: write strobe, valid with sel.
REQ-008 The module SHALL have port re, input, 1 bit: read strobe, valid with sel.
REQ-009 The module SHALL have port wdata, input, XLEN bits: write data.
REQ-010 The module SHALL have port rdata, output, XLEN bits: read data, registered.
REQ-011 The module SHALL have port tx, output, 1 bit: serial transmit line, idle high.
REQ-012 The module SHALL have port rx, input, 1 bit: serial receive line, asynchronous, idle high.

Function
REQ-013 Register map (full address compare) SHALL be: TXDATA 0x1000_0000 (W), RXDATA 0x1000_0004 (R), STATUS 0x1000_0008 (R).
REQ-014 Access timing: a read accepted with sel&re SHALL present rdata on the next cycle; a write with sel&we SHALL take effect at the same clock edge; accesses never stall.
REQ-015 Unmapped offsets and read-only registers: writes SHALL be ignored; unmapped reads SHALL return 0.
REQ-016 TXDATA write: wdata[7:0] SHALL be pushed to the TX FIFO; a write while the FIFO is full SHALL be dropped and SHALL set sticky STATUS[4] tx_overflow.
REQ-017 TX FSM states SHALL be IDLE, START, DATA, STOP. In IDLE with the FIFO non-empty, the FSM SHALL pop one byte and go to START on the next edge.
REQ-018 Each TX state SHALL hold tx for exactly BAUD_DIV cycles: START drives 0; DATA drives bits 0..7, LSB first (8N1 framing); STOP drives 1.
REQ-019 After STOP, the FSM SHALL go to START directly when the FIFO is non-empty (back-to-back frames, no idle gap), else to IDLE.
REQ-020 A simultaneous FIFO push and pop SHALL be legal in any fill state, including full; the count is then unchanged and no overflow is flagged.
REQ-021 The FIFO read and write pointers SHALL wrap modulo TX_FIFO_DEPTH.
REQ-022 STATUS bits SHALL be: [0] tx_full; [1] tx_idle (FIFO empty and FSM in IDLE); [2] rx_valid; [3] rx_overrun; [4] tx_overflow; all others 0.
REQ-023 Any STATUS read SHALL clear bits [3] and [4] after returning them; a set event in the same cycle as the clearing read SHALL win.

Reset
REQ-024 With rst high at a clock edge, the following SHALL reset: tx=1, rdata=0, FIFO empty with pointers at 0, TX FSM=IDLE, baud counters=0, all STATUS flags=0, rx holding register=0.
REQ-025 Reset during a frame SHALL abort the frame immediately; tx SHALL be 1 the cycle after reset, and the queued bytes SHALL be discarded.

Configuration
REQ-026 With macro COTM32_UART_RX_EN defined, the receiver SHALL be built:
- rx passes through a 2-flop synchronizer;
- a falling edge in idle starts a frame; the start bit is re-checked at BAUD_DIV/2, and a high sample returns to idle;
- 8 data bits are sampled at mid-bit, LSB first, followed by the stop bit;
- on the stop sample the byte SHALL load the holding register and set rx_valid; if rx_valid was already 1, rx_overrun SHALL also be set and the new byte SHALL overwrite the old one.
REQ-027 An RXDATA read SHALL return {24'b0, byte} and SHALL clear rx_valid; with COTM32_UART_RX_EN undefined, RXDATA and STATUS[3:2] SHALL read 0 and rx SHALL be unused.

Verification
REQ-028 The bench SHALL cover (all with BAUD_DIV=4):
- Write TXDATA=0xA5 → tx low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; STATUS[1]=1 afterwards.
- 5 back-to-back TXDATA writes with TX_FIFO_DEPTH=4 and the first byte already popped → 5 contiguous frames, 40+10 bit-times with no idle gap; STATUS[4]=0.
- 6 writes in consecutive cycles → 1 popped, 4 queued, 1 dropped; STATUS reads 0x11, then 0x01 on the next read.
- With COTM32_UART_RX_EN defined: drive a 0x3C frame on rx → STATUS[2]=1, and an RXDATA read returns 0x0000_003C, then STATUS[2]=0.
- Two received frames with no intervening read → RXDATA returns the second byte and STATUS[3]=1.
- Assert rst mid-DATA → tx=1 the next cycle and STATUS=0x02; a 1-cycle low glitch on rx is rejected with rx_valid staying 0.
